// File: rtl/plru_way_alloc.sv
// plru_way_alloc: pool allocator picking the lowest free entry, else the tree-PLRU victim,
// with an evict handshake before granting an occupied entry.
module plru_way_alloc #(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [IDXW-1:0]  alloc_idx,
    output logic [WIDTH-1:0] alloc_oh,
    output logic             evict_req,
    output logic [IDXW-1:0]  evict_idx,
    input  logic             evict_ack,
    input  logic             touch_en,
    input  logic [IDXW-1:0]  touch_idx,
    input  logic             free_en,
    input  logic [IDXW-1:0]  free_idx,
    output logic [WIDTH-1:0] valid_vec,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EVICT, GRANT} state_t;

    state_t           state;
    logic [WIDTH-2:0] nodes;
    logic [WIDTH-2:0] nodes_nxt;
    logic [WIDTH-1:0] valid_nxt;
    logic [IDXW-1:0]  v;
    logic [IDXW-1:0]  victim;
    logic [IDXW-1:0]  first_free;
    logic [IDXW-1:0]  sel;

    // Walk t's path from the root, pointing every node away from t.
    function automatic logic [WIDTH-2:0] touch(input logic [WIDTH-2:0] n, input logic [IDXW-1:0] t);
        logic [WIDTH-2:0] r;
        int k;
        r = n;
        k = 0;
        for (int l = 0; l < IDXW; l++) begin
            r[k] = ~t[IDXW-1-l];
            k = 2 * k + 1 + int'(t[IDXW-1-l]);
        end
        return r;
    endfunction

    always_comb begin
        int k;
        k = 0;
        for (int l = 0; l < IDXW; l++)
            k = 2 * k + 1 + int'(nodes[k]);
        victim = IDXW'(k - (WIDTH - 1));
    end

    always_comb begin
        first_free = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (!valid_vec[i]) first_free = IDXW'(i);
    end

    assign sel = &valid_vec ? victim : first_free;

    // Grant updates come last so they win over same-cycle touch and free.
    always_comb begin
        nodes_nxt = touch_en ? touch(nodes, touch_idx) : nodes;
        if (state == GRANT) nodes_nxt = touch(nodes_nxt, v);
        valid_nxt = valid_vec;
        if (free_en) valid_nxt[free_idx] = 1'b0;
        if (state == EVICT && evict_ack) valid_nxt[v] = 1'b0;
        if (state == GRANT) valid_nxt[v] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            nodes     <= '0;
            valid_vec <= '0;
            v         <= '0;
        end else begin
            nodes     <= nodes_nxt;
            valid_vec <= valid_nxt;
            case (state)
                IDLE: if (alloc_req) begin
                    v     <= sel;
                    state <= valid_vec[sel] ? EVICT : GRANT;
                end
                EVICT: if (evict_ack) state <= GRANT;
                default: state <= IDLE;
            endcase
        end
    end

    assign alloc_gnt = state == GRANT;
    assign alloc_idx = alloc_gnt ? v : '0;
    assign alloc_oh  = alloc_gnt ? WIDTH'(1) << v : '0;
    assign evict_req = state == EVICT;
    assign evict_idx = evict_req ? v : '0;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_plru_way_alloc.sv
// tb_plru_way_alloc: directed per-cycle vector table plus a reset-mid-evict sequence.
module tb_plru_way_alloc;
    logic       clk;
    logic       rst_n;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [1:0] alloc_idx;
    logic [3:0] alloc_oh;
    logic       evict_req;
    logic [1:0] evict_idx;
    logic       evict_ack;
    logic       touch_en;
    logic [1:0] touch_idx;
    logic       free_en;
    logic [1:0] free_idx;
    logic [3:0] valid_vec;
    logic       busy;

    plru_way_alloc #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
        .alloc_idx(alloc_idx), .alloc_oh(alloc_oh), .evict_req(evict_req),
        .evict_idx(evict_idx), .evict_ack(evict_ack), .touch_en(touch_en),
        .touch_idx(touch_idx), .free_en(free_en), .free_idx(free_idx),
        .valid_vec(valid_vec), .busy(busy)
    );

    typedef struct {
        logic       req, ack, ten;
        logic [1:0] tidx;
        logic       fen;
        logic [1:0] fidx;
        logic       gnt;
        logic [1:0] idx;
        logic [3:0] oh;
        logic       ereq;
        logic [1:0] eidx;
        logic [3:0] vv;
        logic       bsy;
        logic [2:0] nd;
    } vec_t;

    localparam int N = 25;
    vec_t tbl [N];
    int   nvec = 0;
    int   errs = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int step, input logic [3:0] act, input logic [3:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL step %0d %s: got %h expected %h", step, nm, act, exp);
        end
    endtask

    task automatic chk_all(input int s, input logic g, input logic [1:0] i, input logic [3:0] o,
                           input logic er, input logic [1:0] ei, input logic [3:0] vv,
                           input logic b, input logic [2:0] nd);
        chk("alloc_gnt", s, 4'(alloc_gnt), 4'(g));
        chk("alloc_idx", s, 4'(alloc_idx), 4'(i));
        chk("alloc_oh", s, alloc_oh, o);
        chk("evict_req", s, 4'(evict_req), 4'(er));
        chk("evict_idx", s, 4'(evict_idx), 4'(ei));
        chk("valid_vec", s, valid_vec, vv);
        chk("busy", s, 4'(busy), 4'(b));
        chk("nodes", s, 4'(dut.nodes), 4'(nd));
    endtask

    task automatic drive(input logic r, input logic a, input logic te, input logic [1:0] ti,
                         input logic fe, input logic [1:0] fi);
        alloc_req = r; evict_ack = a; touch_en = te; touch_idx = ti; free_en = fe; free_idx = fi;
    endtask

    initial begin
        // fill from reset, one grant every two cycles
        tbl[0]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b1,2'd0,4'b0001,1'b0,2'd0,4'b0000,1'b1,3'b000};
        tbl[1]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b0001,1'b0,3'b011};
        tbl[2]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b1,2'd1,4'b0010,1'b0,2'd0,4'b0001,1'b1,3'b011};
        tbl[3]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b0011,1'b0,3'b001};
        tbl[4]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b1,2'd2,4'b0100,1'b0,2'd0,4'b0011,1'b1,3'b001};
        tbl[5]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b0111,1'b0,3'b100};
        tbl[6]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b1,2'd3,4'b1000,1'b0,2'd0,4'b0111,1'b1,3'b100};
        tbl[7]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b1111,1'b0,3'b000};
        // PLRU victim 0, free of v during EVICT, ack after three low cycles
        tbl[8]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b1,2'd0,4'b1111,1'b1,3'b000};
        tbl[9]  = '{1'b0,1'b0,1'b0,2'd0,1'b1,2'd0, 1'b0,2'd0,4'b0000,1'b1,2'd0,4'b1110,1'b1,3'b000};
        tbl[10] = '{1'b0,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b1,2'd0,4'b1110,1'b1,3'b000};
        tbl[11] = '{1'b0,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b1,2'd0,4'b1110,1'b1,3'b000};
        tbl[12] = '{1'b0,1'b1,1'b0,2'd0,1'b0,2'd0, 1'b1,2'd0,4'b0001,1'b0,2'd0,4'b1110,1'b1,3'b000};
        // GRANT collides with touch 3 and free 0: grant wins both
        tbl[13] = '{1'b0,1'b0,1'b1,2'd3,1'b1,2'd0, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b1111,1'b0,3'b011};
        // stray ack in IDLE
        tbl[14] = '{1'b0,1'b1,1'b0,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b1111,1'b0,3'b011};
        // restore post-fill nodes, then touch 0 steers victim to 2
        tbl[15] = '{1'b0,1'b0,1'b1,2'd1,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b1111,1'b0,3'b001};
        tbl[16] = '{1'b0,1'b0,1'b1,2'd3,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b1111,1'b0,3'b000};
        tbl[17] = '{1'b0,1'b0,1'b1,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b1111,1'b0,3'b011};
        tbl[18] = '{1'b1,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b1,2'd2,4'b1111,1'b1,3'b011};
        tbl[19] = '{1'b0,1'b1,1'b0,2'd0,1'b0,2'd0, 1'b1,2'd2,4'b0100,1'b0,2'd0,4'b1011,1'b1,3'b011};
        tbl[20] = '{1'b0,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b1111,1'b0,3'b110};
        // free preferred over PLRU; free of v in GRANT loses to set
        tbl[21] = '{1'b0,1'b0,1'b0,2'd0,1'b1,2'd1, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b1101,1'b0,3'b110};
        tbl[22] = '{1'b1,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b1,2'd1,4'b0010,1'b0,2'd0,4'b1101,1'b1,3'b110};
        tbl[23] = '{1'b0,1'b0,1'b0,2'd0,1'b1,2'd1, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b1111,1'b0,3'b101};
        tbl[24] = '{1'b0,1'b0,1'b0,2'd0,1'b0,2'd0, 1'b0,2'd0,4'b0000,1'b0,2'd0,4'b1111,1'b0,3'b101};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        #12;
        chk_all(-1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            drive(tbl[i].req, tbl[i].ack, tbl[i].ten, tbl[i].tidx, tbl[i].fen, tbl[i].fidx);
            @(posedge clk);
            #1;
            chk_all(i, tbl[i].gnt, tbl[i].idx, tbl[i].oh, tbl[i].ereq, tbl[i].eidx,
                    tbl[i].vv, tbl[i].bsy, tbl[i].nd);
        end

        // reset asserted mid-EVICT (victim 3 from nodes 101)
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        chk_all(100, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd3, 4'b1111, 1'b1, 3'b101);
        alloc_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(101, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        alloc_req = 1'b1;
        @(posedge clk);
        #1;
        chk_all(102, 1'b1, 2'd0, 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b1, 3'b000);
        alloc_req = 1'b0;
        @(posedge clk);
        #1;
        chk_all(103, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b0, 3'b011);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
